fetch_unit: RTL and testbench



---
 rtl/y86_pkg.sv | 54 +++++
 rtl/fetch_align.sv | 54 +++++
 rtl/fetch_unit.sv | 251 +++++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch stage.
//   - instruction codes (HALT..POPQ)
//   - status codes (AOK/HLT/ADR/INS)
//   - REG_NONE, the "no register" specifier
//   - fetch FSM state type
//   - instr_len(): encoded length in bytes of an instruction by icode
//   - icode_valid(): icode is a defined instruction
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StWord0,
        StWord1,
        StDone
    } fetch_state_e;

    // Undefined icodes report length 1 so that valP = PC+1 for INS.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            I_HALT, I_NOP, I_RET:                len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:    len = 4'd2;
            I_JXX, I_CALL:                       len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        len = 4'd10;
            default:                             len = 4'd1;
        endcase
        return len;
    endfunction

    function automatic logic icode_valid(input logic [3:0] icode);
        return icode <= I_POPQ;
    endfunction

endpackage

// File: rtl/fetch_align.sv
// Combinational field extractor for the fetch stage.
// Shifts the 16-byte buffer {word1, word0} right by offset bytes and pulls out
// the instruction fields from the resulting byte window.
//   word0_i   in  64  lower memory word (byte 0 in bits 7:0)
//   word1_i   in  64  following memory word
//   offset_i  in  3   byte offset of the instruction within word0
//   icode_o   out 4   high nibble of byte 0
//   ifun_o    out 4   low nibble of byte 0
//   ra_o      out 4   high nibble of byte 1, or REG_NONE if no register byte
//   rb_o      out 4   low nibble of byte 1, or REG_NONE if no register byte
//   valc_o    out 64  constant word, 0 if the instruction has none
module fetch_align
    import y86_pkg::*;
(
    input  logic [63:0] word0_i,
    input  logic [63:0] word1_i,
    input  logic [2:0]  offset_i,
    output logic [3:0]  icode_o,
    output logic [3:0]  ifun_o,
    output logic [3:0]  ra_o,
    output logic [3:0]  rb_o,
    output logic [63:0] valc_o
);

    logic [127:0] pair;
    logic [79:0]  win;   // longest instruction is 10 bytes

    assign pair = {word1_i, word0_i};
    assign win  = 80'(pair >> {offset_i, 3'b000});

    always_comb begin
        icode_o = win[7:4];
        ifun_o  = win[3:0];
        ra_o    = REG_NONE;
        rb_o    = REG_NONE;
        valc_o  = '0;
        case (win[7:4])
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                ra_o = win[15:12];
                rb_o = win[11:8];
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                ra_o   = win[15:12];
                rb_o   = win[11:8];
                valc_o = win[79:16];
            end
            I_JXX, I_CALL: begin
                valc_o = win[71:8];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle Y86-64 fetch stage.
// Reads one or two aligned 64-bit words from instruction memory over a
// req/rvalid handshake, decodes the instruction at PCaddress and presents the
// fields with a one-cycle fValid pulse. All outputs are registered.
//   clk          in  1   clock
//   rst          in  1   synchronous active-high reset
//   start        in  1   begin a fetch at PCaddress (only accepted when idle)
//   PCaddress    in  64  byte address of the instruction
//   imem_req     out 1   memory read request, held until rvalid
//   imem_addr    out 64  8-byte-aligned word address of the request
//   imem_rvalid  in  1   response strobe
//   imem_rdata   in  64  response word, little-endian
//   imem_err     in  1   access fault, qualified by imem_rvalid
//   busy         out 1   fetch in progress (low in the fValid cycle)
//   fValid       out 1   one-cycle pulse, f* outputs updated
//   fIcode/fIfun/fRA/fRB/fValC/fValP/fStat  decoded instruction and status
module fetch_unit
    import y86_pkg::*;
#(
    parameter logic [63:0] MAX_ADDR = 64'h0000_0000_0000_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] PCaddress,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [63:0] imem_rdata,
    input  logic        imem_err,
    output logic        busy,
    output logic        fValid,
    output logic [3:0]  fIcode,
    output logic [3:0]  fIfun,
    output logic [3:0]  fRA,
    output logic [3:0]  fRB,
    output logic [63:0] fValC,
    output logic [63:0] fValP,
    output logic [2:0]  fStat
);

    fetch_state_e state_q, state_d;
    logic         adr_d;          // the fetch being completed ends in an address fault

    logic [63:0]  pc_q;
    logic [63:0]  word0_q;

    logic         req_q, req_d;
    logic [63:0]  addr_q, addr_d;
    logic         busy_q, busy_d;
    logic         fvalid_q, fvalid_d;
    logic [3:0]   icode_q, icode_d;
    logic [3:0]   ifun_q, ifun_d;
    logic [3:0]   ra_q, ra_d;
    logic [3:0]   rb_q, rb_d;
    logic [63:0]  valc_q, valc_d;
    logic [63:0]  valp_q, valp_d;
    logic [2:0]   stat_q, stat_d;

    logic [63:0]  aligned_pc;
    logic [63:0]  pc_sel;
    logic [63:0]  next_addr;
    logic [63:0]  al_word0;
    logic [63:0]  al_word1;
    logic [3:0]   al_icode, al_ifun, al_ra, al_rb;
    logic [63:0]  al_valc;
    logic [3:0]   len;
    logic [4:0]   span;
    logic         need_word1;

    assign aligned_pc = {PCaddress[63:3], 3'b000};
    // A fault straight out of IDLE happens before the PC is latched.
    assign pc_sel     = (state_q == StIdle) ? PCaddress : pc_q;
    assign next_addr  = addr_q + 64'd8;

    // Decode straight from the response word so the result can be registered
    // in the same cycle rvalid arrives.
    assign al_word0 = (state_q == StWord0) ? imem_rdata : word0_q;
    assign al_word1 = (state_q == StWord1) ? imem_rdata : 64'd0;

    fetch_align u_align (
        .word0_i  (al_word0),
        .word1_i  (al_word1),
        .offset_i (pc_q[2:0]),
        .icode_o  (al_icode),
        .ifun_o   (al_ifun),
        .ra_o     (al_ra),
        .rb_o     (al_rb),
        .valc_o   (al_valc)
    );

    assign len        = instr_len(al_icode);
    assign span       = {2'b00, pc_q[2:0]} + {1'b0, len};
    assign need_word1 = icode_valid(al_icode) && (span > 5'd8);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        adr_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (aligned_pc > MAX_ADDR) begin
                        state_d = StDone;
                        adr_d   = 1'b1;
                    end else begin
                        state_d = StWord0;
                    end
                end
            end
            StWord0: begin
                if (imem_rvalid) begin
                    if (imem_err) begin
                        state_d = StDone;
                        adr_d   = 1'b1;
                    end else if (need_word1) begin
                        if (next_addr > MAX_ADDR) begin
                            state_d = StDone;
                            adr_d   = 1'b1;
                        end else begin
                            state_d = StWord1;
                        end
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StWord1: begin
                if (imem_rvalid) begin
                    state_d = StDone;
                    adr_d   = imem_err;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next-values; everything is registered below.
    always_comb begin
        req_d    = (state_d == StWord0) || (state_d == StWord1);
        busy_d   = req_d;
        fvalid_d = (state_d == StDone);

        addr_d = addr_q;
        if (state_q == StIdle && state_d == StWord0) begin
            addr_d = aligned_pc;
        end else if (state_q == StWord0 && state_d == StWord1) begin
            addr_d = next_addr;
        end

        icode_d = icode_q;
        ifun_d  = ifun_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        valc_d  = valc_q;
        valp_d  = valp_q;
        stat_d  = stat_q;

        if (fvalid_d) begin
            if (adr_d) begin
                // Instruction bytes are unusable: present a nop bubble.
                icode_d = I_NOP;
                ifun_d  = 4'h0;
                ra_d    = REG_NONE;
                rb_d    = REG_NONE;
                valc_d  = '0;
                valp_d  = pc_sel;
                stat_d  = STAT_ADR;
            end else begin
                // Undefined icodes get len 1 and valC 0 from the helpers.
                icode_d = al_icode;
                ifun_d  = al_ifun;
                ra_d    = al_ra;
                rb_d    = al_rb;
                valc_d  = al_valc;
                valp_d  = pc_q + 64'(len);
                if (!icode_valid(al_icode)) begin
                    stat_d = STAT_INS;
                end else if (al_icode == I_HALT) begin
                    stat_d = STAT_HLT;
                end else begin
                    stat_d = STAT_AOK;
                end
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            word0_q  <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            fvalid_q <= 1'b0;
            icode_q  <= I_NOP;
            ifun_q   <= 4'h0;
            ra_q     <= REG_NONE;
            rb_q     <= REG_NONE;
            valc_q   <= '0;
            valp_q   <= '0;
            stat_q   <= STAT_AOK;
        end else begin
            if (state_q == StIdle && start) begin
                pc_q <= PCaddress;
            end
            if (state_q == StWord0 && imem_rvalid && !imem_err) begin
                word0_q <= imem_rdata;
            end
            req_q    <= req_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            fvalid_q <= fvalid_d;
            icode_q  <= icode_d;
            ifun_q   <= ifun_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            valc_q   <= valc_d;
            valp_q   <= valp_d;
            stat_q   <= stat_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign busy      = busy_q;
    assign fValid    = fvalid_q;
    assign fIcode    = icode_q;
    assign fIfun     = ifun_q;
    assign fRA       = ra_q;
    assign fRB       = rb_q;
    assign fValC     = valc_q;
    assign fValP     = valp_q;
    assign fStat     = stat_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a vector table of fetches is driven through a
// one-cycle-latency memory model; expected results are queued at start and
// checked when fValid appears. Hand-written sequences cover reset, start while
// busy and reset in the middle of a two-word fetch.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] PCaddress;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [63:0] imem_rdata;
    logic        imem_err;
    logic        busy;
    logic        fValid;
    logic [3:0]  fIcode, fIfun, fRA, fRB;
    logic [63:0] fValC, fValP;
    logic [2:0]  fStat;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .PCaddress   (PCaddress),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .busy        (busy),
        .fValid      (fValid),
        .fIcode      (fIcode),
        .fIfun       (fIfun),
        .fRA         (fRA),
        .fRB         (fRB),
        .fValC       (fValC),
        .fValP       (fValP),
        .fStat       (fStat)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] w0;       // word at the aligned PC
        logic [63:0] w1;       // word at aligned PC + 8
        int          err_sel;  // 0 none, 1 fault on first read, 2 on second
        int          nreads;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [2:0]  stat;
        int          lat;      // cycles from start to fValid
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          fvalid_cnt = 0;
    int          rd_cnt = 0;
    vec_t        exp_q[$];
    int          st_q[$];
    logic [63:0] m_base = 64'd0;
    logic [63:0] m_w0 = 64'd0;
    logic [63:0] m_w1 = 64'd0;
    int          m_err_sel = 0;
    bit          block_w1 = 1'b0;
    bit          inject_rv = 1'b0;
    logic [63:0] inj_data = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: answers one cycle after a request is first seen.
    initial begin
        bit req_prev;
        req_prev    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 64'd0;
        imem_err    = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (start) rd_cnt = 0;
            if (inject_rv) begin
                imem_rvalid = 1'b1;
                imem_rdata  = inj_data;
                imem_err    = 1'b0;
            end else if (imem_req && req_prev && !imem_rvalid &&
                         !(block_w1 && imem_addr == m_base + 64'd8)) begin
                chk($sformatf("read_addr_%0d", rd_cnt), imem_addr, m_base + 64'(rd_cnt) * 64'd8);
                imem_rvalid = 1'b1;
                imem_rdata  = (imem_addr == m_base) ? m_w0 : m_w1;
                imem_err    = (m_err_sel == rd_cnt + 1);
                rd_cnt++;
            end else begin
                imem_rvalid = 1'b0;
                imem_err    = 1'b0;
                imem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            req_prev = imem_req;
        end
    end

    // Scoreboard checker.
    initial forever begin
        vec_t e;
        int   s;
        string p;
        @(posedge clk);
        #1;
        if (fValid) begin
            fvalid_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_fvalid", fValid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                s = st_q.pop_front();
                p = $sformatf("pc%0h", e.pc);
                chk({p, "_icode"}, fIcode, e.icode);
                chk({p, "_ifun"}, fIfun, e.ifun);
                chk({p, "_rA"}, fRA, e.ra);
                chk({p, "_rB"}, fRB, e.rb);
                chk({p, "_valC"}, fValC, e.valc);
                chk({p, "_valP"}, fValP, e.valp);
                chk({p, "_stat"}, fStat, e.stat);
                chk({p, "_latency"}, cyc - s, e.lat);
                chk({p, "_reads"}, rd_cnt, e.nreads);
                chk({p, "_busy_at_fvalid"}, busy, 1'b0);
            end
        end
    end

    task automatic load_mem(input vec_t v);
        m_base    = {v.pc[63:3], 3'b000};
        m_w0      = v.w0;
        m_w1      = v.w1;
        m_err_sel = v.err_sel;
    endtask

    task automatic run_vec(input vec_t v);
        int n0;
        load_mem(v);
        @(posedge clk);
        #1;
        PCaddress = v.pc;
        start     = 1'b1;
        exp_q.push_back(v);
        st_q.push_back(cyc);
        n0 = fvalid_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 20 && fvalid_cnt == n0; k++) @(posedge clk);
        #2;
        chk($sformatf("pc%0h_done_in_budget", v.pc), (fvalid_cnt != n0), 1'b1);
        if (fvalid_cnt == n0) begin
            void'(exp_q.pop_back());
            void'(st_q.pop_back());
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_reset_outputs(input string p);
        chk({p, "_imem_req"}, imem_req, 1'b0);
        chk({p, "_imem_addr"}, imem_addr, 64'd0);
        chk({p, "_busy"}, busy, 1'b0);
        chk({p, "_fValid"}, fValid, 1'b0);
        chk({p, "_fIcode"}, fIcode, 4'h1);
        chk({p, "_fIfun"}, fIfun, 4'h0);
        chk({p, "_fRA"}, fRA, 4'hF);
        chk({p, "_fRB"}, fRB, 4'hF);
        chk({p, "_fValC"}, fValC, 64'd0);
        chk({p, "_fValP"}, fValP, 64'd0);
        chk({p, "_fStat"}, fStat, 3'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        vec_t v;
        int   n0;

        //            pc            w0                      w1                      err rd ic    if    rA    rB    valC                    valP          stat lat
        vecs[0]  = '{64'h0,     64'h0000_0000_000A_F230, 64'h0,                  0, 2, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10,                 64'd10,       3'd1, 5};
        vecs[1]  = '{64'h6,     64'h0120_0000_0000_0000, 64'h0,                  0, 1, 4'h2, 4'h0, 4'h0, 4'h1, 64'd0,                  64'd8,        3'd1, 3};
        vecs[2]  = '{64'h7,     64'h6000_0000_0000_0000, 64'h23,                 0, 2, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0,                  64'd9,        3'd1, 5};
        vecs[3]  = '{64'h0,     64'hC0,                  64'h0,                  0, 1, 4'hC, 4'h0, 4'hF, 4'hF, 64'd0,                  64'd1,        3'd4, 3};
        vecs[4]  = '{64'h0,     64'h1122_3344_5566_7700, 64'h0,                  0, 1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0,                  64'd1,        3'd2, 3};
        vecs[5]  = '{64'h4,     64'h0000_0080_0000_0000, 64'h0,                  2, 2, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0,                  64'd4,        3'd3, 5};
        vecs[6]  = '{64'h10000, 64'h0,                   64'h0,                  0, 0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0,                  64'h10000,    3'd3, 1};
        vecs[7]  = '{64'h1B,    64'h6677_88F5_3000_0000, 64'h0000_0011_2233_4455, 0, 2, 4'h3, 4'h0, 4'hF, 4'h5, 64'h1122_3344_5566_7788, 64'h25,      3'd1, 5};
        vecs[8]  = '{64'h20,    64'h0000_0000_0012_3473, 64'h0,                  0, 2, 4'h7, 4'h3, 4'hF, 4'hF, 64'h1234,               64'h29,       3'd1, 5};
        vecs[9]  = '{64'hFFFF,  64'h9000_0000_0000_0000, 64'h0,                  0, 1, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0,                  64'h10000,    3'd1, 3};
        vecs[10] = '{64'hFFFF,  64'h2000_0000_0000_0000, 64'h0,                  0, 1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0,                  64'hFFFF,     3'd3, 3};
        vecs[11] = '{64'h40,    64'h10,                  64'h0,                  1, 1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0,                  64'h40,       3'd3, 3};

        rst       = 1'b1;
        start     = 1'b0;
        PCaddress = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("reset");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Start held high while the fetch is already running.
        v = vecs[1];
        load_mem(v);
        @(posedge clk);
        #1;
        PCaddress = v.pc;
        start     = 1'b1;
        exp_q.push_back(v);
        st_q.push_back(cyc);
        n0 = fvalid_cnt;
        @(posedge clk);
        #1;
        PCaddress = 64'h40;
        chk("busy_after_start", busy, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("one_fvalid_for_start_while_busy", fvalid_cnt - n0, 1);
        chk("idle_after_start_while_busy", imem_req, 1'b0);

        // Reset while waiting for the second word, then a late response.
        v = vecs[0];
        load_mem(v);
        block_w1 = 1'b1;
        @(posedge clk);
        #1;
        PCaddress = v.pc;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 10 && !(imem_req && imem_addr == 64'd8); k++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_second_read", imem_req && imem_addr == 64'd8, 1'b1);
        n0  = fvalid_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        inj_data  = v.w1;
        inject_rv = 1'b1;
        chk_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        inject_rv = 1'b0;
        chk("req_after_late_rvalid", imem_req, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        chk("no_fvalid_after_mid_rst", fvalid_cnt - n0, 0);
        chk("busy_after_mid_rst", busy, 1'b0);
        block_w1 = 1'b0;

        // Normal operation resumes after the aborted fetch.
        run_vec(vecs[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
